// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: access size encoding,
// FSM state and owner enums, and the alignment helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_access_size_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    ERROR
  } arb_state_t;

  typedef enum logic {
    OWNER_FETCH,
    OWNER_DATA
  } arb_owner_t;

  // The low two address bits must be zero for the access size.
  // An unknown size encoding is treated as misaligned so that it errors out.
  function automatic logic is_aligned(input mem_access_size_t size, input logic [1:0] lsb);
    case (size)
      SIZE_BYTE: is_aligned = 1'b1;
      SIZE_HALF: is_aligned = ~lsb[0];
      SIZE_WORD: is_aligned = (lsb == 2'b00);
      default:   is_aligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch requester, the data requester and the memory bus around
// the arbiter.
//   slave  : the arbiter's view (it serves the core requesters and drives the bus)
//   master : the surrounding core + memory side
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction fetch requester
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;
  // data requester
  logic              d_req_i;
  logic              d_we_i;
  mem_access_size_t  d_size_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic              d_gnt_o;
  logic              d_rvalid_o;
  logic [DATA_W-1:0] d_rdata_o;
  // memory bus
  logic              mem_req_o;
  logic              mem_we_o;
  mem_access_size_t  mem_size_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_err_i;
  // sticky error to the core
  logic              err_o;

  modport slave (
    input  if_req_i, if_addr_i,
    input  d_req_i, d_we_i, d_size_i, d_addr_i, d_wdata_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    output d_gnt_o, d_rvalid_o, d_rdata_o,
    output mem_req_o, mem_we_o, mem_size_o, mem_addr_o, mem_wdata_o,
    output err_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output d_req_i, d_we_i, d_size_i, d_addr_i, d_wdata_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    input  d_gnt_o, d_rvalid_o, d_rdata_o,
    input  mem_req_o, mem_we_o, mem_size_o, mem_addr_o, mem_wdata_o,
    input  err_o
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one external memory port between the instruction-fetch and the
//   data requesters, one transaction outstanding at a time. Two-way
//   round-robin, alignment check, bounded latency (timeout) and a sticky
//   error output.
// Ports
//   clk_i    : clock, rising edge
//   reset_i  : asynchronous, active-high reset
//   bus      : mem_port_arbiter_if.slave -- fetch req/gnt/rvalid/rdata,
//              data req/we/size/addr/wdata/gnt/rvalid/rdata, memory
//              req/cmd/gnt/rvalid/rdata/err, and err_o.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk_i,
  input  logic                reset_i,
  mem_port_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef struct packed {
    logic              we;
    mem_access_size_t  size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, last_owner_q;
  cmd_t              cmd_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;

  // Round-robin pick: fetch wins unless data is asking and fetch had the port last.
  logic pick_fetch, pick_data, any_req, sel_ok, grant, tmo_hit;

  assign any_req    = bus.if_req_i | bus.d_req_i;
  assign pick_fetch = bus.if_req_i & (~bus.d_req_i | (last_owner_q == OWNER_DATA));
  assign pick_data  = bus.d_req_i & ~pick_fetch;
  assign sel_ok     = pick_fetch ? (bus.if_addr_i[1:0] == 2'b00)
                                 : is_aligned(bus.d_size_i, bus.d_addr_i[1:0]);
  // reset_i gates the grant so no gnt leaks out while reset is held.
  assign grant      = (state_q == IDLE) & ~reset_i & any_req & sel_ok;
  // Last permitted cycle in ISSUE+WAIT.
  assign tmo_hit    = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // ---------------- state register + datapath ----------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      owner_q      <= OWNER_FETCH;
      last_owner_q <= OWNER_DATA;
      cmd_q        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q <= state_d;

      if (grant) begin
        owner_q <= pick_fetch ? OWNER_FETCH : OWNER_DATA;
        err_q   <= 1'b0;
        cnt_q   <= '0;
        if (pick_fetch) begin
          cmd_q.we    <= 1'b0;
          cmd_q.size  <= SIZE_WORD;
          cmd_q.addr  <= bus.if_addr_i;
          cmd_q.wdata <= '0;
        end else begin
          cmd_q.we    <= bus.d_we_i;
          cmd_q.size  <= bus.d_size_i;
          cmd_q.addr  <= bus.d_addr_i;
          cmd_q.wdata <= bus.d_wdata_i;
        end
      end else if (state_q == ISSUE || state_q == WAIT) begin
        cnt_q <= cnt_q + 1'b1;
      end

      // Capture the response only on the transition into RESP, so a stray
      // mem_rvalid_i in any other state never disturbs rdata_q/err_q.
      if (state_d == RESP && state_q != RESP) begin
        rdata_q <= cmd_q.we ? '0 : bus.mem_rdata_i;
        err_q   <= bus.mem_err_i;
      end

      if (state_q == RESP) last_owner_q <= owner_q;
    end
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (any_req) state_d = sel_ok ? ISSUE : ERROR;
      // A same-cycle response wins over the timeout; a bare gnt on the last
      // allowed cycle still times out since no response can follow in budget.
      ISSUE: begin
        if (bus.mem_gnt_i && bus.mem_rvalid_i) state_d = RESP;
        else if (tmo_hit)                      state_d = ERROR;
        else if (bus.mem_gnt_i)                state_d = WAIT;
      end
      WAIT: begin
        if (bus.mem_rvalid_i) state_d = RESP;
        else if (tmo_hit)     state_d = ERROR;
      end
      RESP:    state_d = err_q ? ERROR : IDLE;
      ERROR:   state_d = ERROR;
      default: state_d = ERROR;
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    bus.if_gnt_o    = grant & pick_fetch;
    bus.d_gnt_o     = grant & pick_data;
    bus.if_rvalid_o = 1'b0;
    bus.if_rdata_o  = '0;
    bus.d_rvalid_o  = 1'b0;
    bus.d_rdata_o   = '0;
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_size_o  = SIZE_BYTE;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    bus.err_o       = 1'b0;
    case (state_q)
      ISSUE: begin
        bus.mem_req_o   = 1'b1;
        bus.mem_we_o    = cmd_q.we;
        bus.mem_size_o  = cmd_q.size;
        bus.mem_addr_o  = cmd_q.addr;
        bus.mem_wdata_o = cmd_q.wdata;
      end
      RESP: begin
        if (owner_q == OWNER_FETCH) begin
          bus.if_rvalid_o = 1'b1;
          bus.if_rdata_o  = rdata_q;
        end else begin
          bus.d_rvalid_o  = 1'b1;
          bus.d_rdata_o   = rdata_q;
        end
      end
      ERROR:   bus.err_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TIMEOUT_CYCLES = 4).
// Inputs change just after the falling edge; outputs are sampled 1 time unit
// later, well away from the rising edge.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.if_req_i     = 1'b0;
    bus.if_addr_i    = '0;
    bus.d_req_i      = 1'b0;
    bus.d_we_i       = 1'b0;
    bus.d_size_i     = SIZE_WORD;
    bus.d_addr_i     = '0;
    bus.d_wdata_i    = '0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    bus.mem_err_i    = 1'b0;
  endtask

  // Leaves the bench at a falling edge with reset released.
  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int exp_seq[4];
    int gseq[$];
    int outst, nreq;
    bit overlap, too_many, rv;

    // ---------- reset state: fetch held high must not be granted ----------
    idle_inputs();
    rst = 1'b1;
    bus.if_req_i = 1'b1;
    @(negedge clk); #1;
    chk("rst_if_gnt", bus.if_gnt_o, 0);
    chk("rst_mem_req", bus.mem_req_o, 0);
    chk("rst_err", bus.err_o, 0);

    // ---------- 1: single fetch, response two cycles after mem_gnt ----------
    do_reset();
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
    #1 chk("t1_if_gnt", bus.if_gnt_o, 1);
    chk("t1_mem_req_idle", bus.mem_req_o, 0);
    @(negedge clk);
    bus.if_req_i = 1'b0; bus.mem_gnt_i = 1'b1;
    #1 chk("t1_mem_req", bus.mem_req_o, 1);
    chk("t1_mem_addr", bus.mem_addr_o, 32'h100);
    chk("t1_mem_size", bus.mem_size_o, SIZE_WORD);
    chk("t1_mem_we", bus.mem_we_o, 0);
    @(negedge clk);
    bus.mem_gnt_i = 1'b0;
    #1 chk("t1_mem_req_wait", bus.mem_req_o, 0);
    @(negedge clk);
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hDEADBEEF;
    #1 chk("t1_rvalid_early", bus.if_rvalid_o, 0);
    @(negedge clk);
    bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
    #1 chk("t1_if_rvalid", bus.if_rvalid_o, 1);
    chk("t1_if_rdata", bus.if_rdata_o, 32'hDEADBEEF);
    chk("t1_d_rvalid", bus.d_rvalid_o, 0);
    @(negedge clk); #1;
    chk("t1_rvalid_pulse", bus.if_rvalid_o, 0);

    // ---------- 2: both requesters held, round-robin ----------
    do_reset();
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_size_i = SIZE_WORD; bus.d_addr_i = 32'h200;
    outst = 0; overlap = 0; too_many = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      // zero-wait memory: accept and answer in the same cycle
      bus.mem_gnt_i    = bus.mem_req_o;
      bus.mem_rvalid_i = bus.mem_req_o;
      bus.mem_rdata_i  = bus.mem_addr_o ^ 32'hA5A5_0000;
      #1;
      if (bus.if_gnt_o && bus.d_gnt_o) overlap = 1;
      if (bus.if_gnt_o) begin gseq.push_back(0); outst++; end
      if (bus.d_gnt_o)  begin gseq.push_back(1); outst++; end
      if (bus.if_rvalid_o) begin
        chk("t2_if_rdata", bus.if_rdata_o, 32'hA5A5_0100); outst--;
      end
      if (bus.d_rvalid_o) begin
        chk("t2_d_rdata", bus.d_rdata_o, 32'hA5A5_0200); outst--;
      end
      if (outst > 1) too_many = 1;
      @(negedge clk);
    end
    idle_inputs();
    exp_seq = '{0, 1, 0, 1};
    chk("t2_ngnt", gseq.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < gseq.size()) chk($sformatf("t2_gnt%0d_owner", i), gseq[i], exp_seq[i]);
    chk("t2_overlap", overlap, 0);
    chk("t2_outstanding", too_many, 0);

    // ---------- 3: store byte, rdata forced to 0 ----------
    do_reset();
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_size_i = SIZE_BYTE;
    bus.d_addr_i = 32'h203; bus.d_wdata_i = 32'hAB;
    #1 chk("t3_d_gnt", bus.d_gnt_o, 1);
    @(negedge clk);
    bus.d_req_i = 1'b0;
    bus.mem_gnt_i = 1'b1; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h12345678;
    #1 chk("t3_mem_we", bus.mem_we_o, 1);
    chk("t3_mem_size", bus.mem_size_o, SIZE_BYTE);
    chk("t3_mem_addr", bus.mem_addr_o, 32'h203);
    chk("t3_mem_wdata", bus.mem_wdata_o, 32'hAB);
    @(negedge clk);
    idle_inputs();
    #1 chk("t3_d_rvalid", bus.d_rvalid_o, 1);
    chk("t3_d_rdata", bus.d_rdata_o, 0);

    // ---------- 4: misaligned word load -> sticky error ----------
    do_reset();
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_size_i = SIZE_WORD; bus.d_addr_i = 32'h202;
    #1 chk("t4_d_gnt", bus.d_gnt_o, 0);
    @(negedge clk);
    bus.d_addr_i = 32'h204;  // aligned retry must not be served
    #1 chk("t4_err", bus.err_o, 1);
    chk("t4_mem_req", bus.mem_req_o, 0);
    repeat (3) @(negedge clk);
    #1 chk("t4_err_sticky", bus.err_o, 1);
    chk("t4_no_gnt", bus.d_gnt_o, 0);
    do_reset();
    #1 chk("t4_err_cleared", bus.err_o, 0);

    // ---------- 5a: mem_gnt withheld -> timeout after 4 cycles ----------
    do_reset();
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h40;
    #1 chk("t5_if_gnt", bus.if_gnt_o, 1);
    @(negedge clk);
    bus.if_req_i = 1'b0;
    nreq = 0; rv = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus.mem_req_o) nreq++;
      if (bus.if_rvalid_o || bus.d_rvalid_o) rv = 1;
      @(negedge clk);
    end
    chk("t5_issue_cycles", nreq, TMO);
    chk("t5_no_rvalid", rv, 0);
    chk("t5_err", bus.err_o, 1);

    // ---------- 5b: bus error response -> rvalid pulse, then err ----------
    do_reset();
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h44;
    @(negedge clk);
    bus.if_req_i = 1'b0; bus.mem_gnt_i = 1'b1;
    @(negedge clk);
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_err_i = 1'b1; bus.mem_rdata_i = 32'h55;
    @(negedge clk);
    idle_inputs();
    #1 chk("t5b_if_rvalid", bus.if_rvalid_o, 1);
    chk("t5b_if_rdata", bus.if_rdata_o, 32'h55);
    chk("t5b_err_early", bus.err_o, 0);
    @(negedge clk); #1;
    chk("t5b_err", bus.err_o, 1);
    chk("t5b_rvalid_pulse", bus.if_rvalid_o, 0);

    // ---------- 6: reset in WAIT, late response dropped ----------
    do_reset();
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h80;
    @(negedge clk);
    bus.if_req_i = 1'b0; bus.mem_gnt_i = 1'b1;
    #1 chk("t6_mem_req", bus.mem_req_o, 1);
    @(negedge clk);
    bus.mem_gnt_i = 1'b0;
    bus.if_req_i = 1'b1;  // held through reset: must not be granted
    #1 rst = 1'b1;
    #1 chk("t6_rst_gnt", bus.if_gnt_o, 0);
    chk("t6_rst_mem_req", bus.mem_req_o, 0);
    chk("t6_rst_err", bus.err_o, 0);
    @(negedge clk);
    rst = 1'b0; bus.if_req_i = 1'b0;
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hBAD;
    @(negedge clk);
    bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
    #1 chk("t6_late_if_rvalid", bus.if_rvalid_o, 0);
    chk("t6_late_mem_req", bus.mem_req_o, 0);
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_size_i = SIZE_WORD; bus.d_addr_i = 32'h300;
    #1 chk("t6_d_gnt", bus.d_gnt_o, 1);
    @(negedge clk);
    bus.d_req_i = 1'b0;
    bus.mem_gnt_i = 1'b1; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h11223344;
    #1 chk("t6_mem_addr", bus.mem_addr_o, 32'h300);
    @(negedge clk);
    idle_inputs();
    #1 chk("t6_d_rvalid", bus.d_rvalid_o, 1);
    chk("t6_d_rdata", bus.d_rdata_o, 32'h11223344);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
